// File: rtl/anemometer_pkg.sv
// anemometer_pkg: shared FSM state type and elaboration-time sizing helpers.
package anemometer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int gate_cyc(input int clk_hz, input int gate_ms);
    return clk_hz / 1000 * gate_ms;
  endfunction

endpackage

// File: rtl/anemometer_chan.sv
// anemometer_chan: synchroniser, optional glitch filter (ANEMO_GLITCH_FILTER_EN), edge detector, saturating counter.
module anemometer_chan
  import anemometer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
`ifdef ANEMO_GLITCH_FILTER_EN
  , parameter int FILT_CYC  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_freq,
  input  logic              en,
  input  logic              clr,
  output logic [DATA_W-1:0] cnt_nx
);

  logic [SYNC_STAGES-1:0] sr, fill;
  logic                   s, s_vld, q, q_vld, prev, armed, pulse;
  logic [DATA_W-1:0]      cnt;

  assign s     = sr[SYNC_STAGES-1];
  assign s_vld = fill[SYNC_STAGES-1];

  // fill tracks when the chain holds real samples rather than reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      fill <= '0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], in_freq};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

`ifdef ANEMO_GLITCH_FILTER_EN
  localparam int FW = clog2(FILT_CYC + 1);
  logic [FW-1:0] fcnt;
  logic          f, f_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      f     <= 1'b0;
      f_vld <= 1'b0;
    end else if (s_vld) begin
      f_vld <= f_vld | (s == f);
      if (s == f)
        fcnt <= '0;
      else if (fcnt == FW'(FILT_CYC - 1)) begin
        f    <= s;
        fcnt <= '0;
      end else
        fcnt <= fcnt + 1'b1;
    end
  end

  assign q     = f;
  assign q_vld = f_vld;
`else
  assign q     = s;
  assign q_vld = s_vld;
`endif

  // an input already high out of reset must go low once before it can count
  assign pulse  = q & ~prev & armed;
  assign cnt_nx = (en && pulse && cnt != '1) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      prev  <= q;
      armed <= armed | (q_vld & ~q);
      cnt   <= clr ? '0 : cnt_nx;
    end
  end

endmodule

// File: rtl/anemometer_multi.sv
// anemometer_multi: N_CH gated pulse counters sharing one measurement window FSM.
// ANEMO_GLITCH_FILTER_EN adds a FILT_CYC-cycle stability filter per channel.
module anemometer_multi
  import anemometer_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 8,
  parameter int CLK_HZ      = 50000000,
  parameter int GATE_MS     = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 16
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [N_CH-1:0]          in_freq,
  input  logic                     continu,
  input  logic                     start_stop,
  output logic [N_CH*DATA_W-1:0]   data,
  output logic                     data_valid,
  output logic                     busy
);

  localparam int            GATE_CYC  = gate_cyc(CLK_HZ, GATE_MS);
  localparam int            GW        = clog2(GATE_CYC);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);

  if (N_CH < 1 || N_CH > 8 || DATA_W < 4 || DATA_W > 16 || SYNC_STAGES < 2 ||
      FILT_CYC < 1 || GATE_CYC < 1) begin : g_bad_param
    $error("anemometer_multi: parameter out of range");
  end

  state_t                 state, state_nx;
  logic [GW-1:0]          gate;
  logic                   ss_q, go, en, clr, latch, win_end, dv;
  logic [N_CH*DATA_W-1:0] cnt_nx, data_q;

  assign go      = continu ? start_stop : (start_stop & ~ss_q);
  assign en      = state == MEASURE;
  assign win_end = en && gate == GATE_LAST;

  // clr marks every window start: counters and gate clear on the entry edge
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = go ? MEASURE : state;
        clr      = go;
      end
      MEASURE: begin
        latch    = win_end;
        clr      = win_end & continu & start_stop;
        state_nx = !win_end ? MEASURE : !continu ? DONE : start_stop ? MEASURE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= IDLE;
      gate   <= '0;
      ss_q   <= 1'b0;
      dv     <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      ss_q   <= start_stop;
      gate   <= clr ? '0 : en ? gate + 1'b1 : gate;
      dv     <= latch | (dv & ~(clr & ~continu));
      if (latch) data_q <= cnt_nx;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    anemometer_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DATA_W     (DATA_W)
`ifdef ANEMO_GLITCH_FILTER_EN
      , .FILT_CYC (FILT_CYC)
`endif
    ) u_chan (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .in_freq(in_freq[i]),
      .en     (en),
      .clr    (clr),
      .cnt_nx (cnt_nx[i*DATA_W +: DATA_W])
    );
  end

  assign data       = data_q;
  assign data_valid = dv;
  assign busy       = en;

endmodule

// File: tb/tb_anemometer_multi.sv
// tb_anemometer_multi: directed checks of windowing, modes, saturation, reset and glitch handling.
module tb_anemometer_multi;

`ifdef ANEMO_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_freq;
  logic        continu, start_stop;
  logic [15:0] data;
  logic        dv, busy;
  logic [3:0]  data4;
  logic        dv4, busy4;
  int          pass_cnt = 0;
  int          total = 0;
  int          p0 = 0;
  int          p1 = 0;
  int          ph = 0;

  always #5 clk = ~clk;

  anemometer_multi #(
    .N_CH(2), .DATA_W(8), .CLK_HZ(1000), .GATE_MS(100), .SYNC_STAGES(2), .FILT_CYC(4)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_freq(in_freq), .continu(continu),
    .start_stop(start_stop), .data(data), .data_valid(dv), .busy(busy)
  );

  anemometer_multi #(
    .N_CH(1), .DATA_W(4), .CLK_HZ(1000), .GATE_MS(200), .SYNC_STAGES(2), .FILT_CYC(4)
  ) dut4 (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_freq(in_freq[0]), .continu(continu),
    .start_stop(start_stop), .data(data4), .data_valid(dv4), .busy(busy4)
  );

  task automatic tick();
    @(negedge clk);
    ph++;
    if (p0 != 0) in_freq[0] = (ph % p0 == 0);
    if (p1 != 0) in_freq[1] = (ph % p1 == 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    p0 = 0;
    p1 = 0;
    in_freq = 2'b00;
    continu = 1'b0;
    start_stop = 1'b0;
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_freq = 2'b00;
    continu = 1'b0;
    start_stop = 1'b0;
    ticks(2);
    total++; if (data !== 16'd0) $display("FAIL reset_data got %0h want 0", data); else pass_cnt++;
    total++; if (dv !== 1'b0) $display("FAIL reset_dv got %b want 0", dv); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (data4 !== 4'd0) $display("FAIL reset_data4 got %0d want 0", data4); else pass_cnt++;
    rst_n = 1'b1;
    ticks(10);
    total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_continuous();
    int n;
    continu = 1'b1;
    p0 = 10;
    p1 = 5;
    ticks(20);
    start_stop = 1'b1;
    n = 0;
    while (dv !== 1'b1 && n < 300) begin tick(); n++; end
    total++; if (dv !== 1'b1) $display("FAIL cont_dv_rise got %b want 1", dv); else pass_cnt++;
    total++; if (data[7:0] !== 8'd10) $display("FAIL cont_w1_ch0 got %0d want 10", data[7:0]); else pass_cnt++;
    total++; if (data[15:8] !== 8'd20) $display("FAIL cont_w1_ch1 got %0d want 20", data[15:8]); else pass_cnt++;
    ticks(100);
    total++; if (data !== {8'd20, 8'd10}) $display("FAIL cont_w2_data got %0h want 140a", data); else pass_cnt++;
    total++; if (dv !== 1'b1) $display("FAIL cont_dv_hold got %b want 1", dv); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL cont_busy got %b want 1", busy); else pass_cnt++;
    n = 0;
    while (dv4 !== 1'b1 && n < 300) begin tick(); n++; end
    total++; if (data4 !== 4'd15) $display("FAIL sat_20_edges got %0d want 15", data4); else pass_cnt++;
    p0 = 5;
    p1 = 4;
    ticks(450);
    total++; if (data[7:0] !== 8'd20) $display("FAIL cont_b_ch0 got %0d want 20", data[7:0]); else pass_cnt++;
    total++; if (data[15:8] !== 8'd25) $display("FAIL cont_b_ch1 got %0d want 25", data[15:8]); else pass_cnt++;
    total++; if (data4 !== 4'd15) $display("FAIL sat_40_edges got %0d want 15", data4); else pass_cnt++;
    start_stop = 1'b0;
    ticks(250);
    total++; if (busy !== 1'b0) $display("FAIL halt_busy got %b want 0", busy); else pass_cnt++;
    total++; if (busy4 !== 1'b0) $display("FAIL halt_busy4 got %b want 0", busy4); else pass_cnt++;
    total++; if (dv !== 1'b1) $display("FAIL halt_dv got %b want 1", dv); else pass_cnt++;
  endtask

  task automatic test_single_shot();
    int busy_cycles;
    do_reset();
    p0 = 10;
    p1 = 5;
    ticks(20);
    start_stop = 1'b1;
    busy_cycles = 0;
    repeat (500) begin tick(); if (busy === 1'b1) busy_cycles++; end
    total++; if (busy_cycles != 100) $display("FAIL ss_one_window busy_cycles got %0d want 100", busy_cycles); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL ss_done_busy got %b want 0", busy); else pass_cnt++;
    total++; if (dv !== 1'b1) $display("FAIL ss_done_dv got %b want 1", dv); else pass_cnt++;
    total++; if (data !== {8'd20, 8'd10}) $display("FAIL ss_data got %0h want 140a", data); else pass_cnt++;
    start_stop = 1'b0;
    ticks(3);
    start_stop = 1'b1;
    tick();
    total++; if (dv !== 1'b0) $display("FAIL ss_retrig_dv got %b want 0", dv); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL ss_retrig_busy got %b want 1", busy); else pass_cnt++;
    total++; if (data[7:0] !== 8'd10) $display("FAIL ss_old_data got %0d want 10", data[7:0]); else pass_cnt++;
    ticks(99);
    total++; if (dv !== 1'b0) $display("FAIL ss_cycle100_dv got %b want 0", dv); else pass_cnt++;
    tick();
    total++; if (dv !== 1'b1) $display("FAIL ss_cycle101_dv got %b want 1", dv); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL ss_cycle101_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    p0 = 10;
    p1 = 5;
    ticks(20);
    continu = 1'b1;
    start_stop = 1'b1;
    n = 0;
    while (dv !== 1'b1 && n < 300) begin tick(); n++; end
    ticks(50);
    total++; if (data !== {8'd20, 8'd10}) $display("FAIL mid_pre_data got %0h want 140a", data); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (data !== 16'd0) $display("FAIL mid_rst_data got %0h want 0", data); else pass_cnt++;
    total++; if (dv !== 1'b0) $display("FAIL mid_rst_dv got %b want 0", dv); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else pass_cnt++;
    p0 = 0;
    p1 = 0;
    in_freq = 2'b11;
    ticks(2);
    rst_n = 1'b1;
    n = 0;
    while ((dv !== 1'b1 || dv4 !== 1'b1) && n < 400) begin tick(); n++; end
    total++; if (dv !== 1'b1) $display("FAIL high_in_dv got %b want 1", dv); else pass_cnt++;
    total++; if (data !== 16'd0) $display("FAIL high_in_data got %0h want 0", data); else pass_cnt++;
    total++; if (data4 !== 4'd0) $display("FAIL high_in_data4 got %0d want 0", data4); else pass_cnt++;
  endtask

  task automatic test_boundary();
    do_reset();
    continu = 1'b1;
    ticks(5);
    start_stop = 1'b1;
    for (int t = 1; t <= 250; t++) begin
      tick();
      if (t == 98 - LAT) in_freq[0] = 1'b1;
      if (t == 99 - LAT) in_freq[1] = 1'b1;
      if (t == 102) in_freq = 2'b00;
      if (t == 150) begin
        total++; if (data !== {8'd0, 8'd1}) $display("FAIL bound_last_cycle got %0h want 0001", data); else pass_cnt++;
      end
    end
    total++; if (data !== {8'd1, 8'd0}) $display("FAIL bound_first_cycle got %0h want 0100", data); else pass_cnt++;
    total++; if (data4 !== 4'd1) $display("FAIL bound_data4 got %0d want 1", data4); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int n;
    int exp4;
`ifdef ANEMO_GLITCH_FILTER_EN
    exp4 = 10;
`else
    exp4 = 14;
`endif
    do_reset();
    ticks(10);
    start_stop = 1'b1;
    ticks(5);
    for (int u = 0; u < 10; u++) begin
      in_freq[0] = 1'b1;
      ticks(5);
      in_freq[0] = 1'b0;
      ticks(5);
      if (u < 4) begin
        in_freq[0] = 1'b1;
        ticks(2);
        in_freq[0] = 1'b0;
        ticks(4);
      end
    end
    n = 0;
    while (dv4 !== 1'b1 && n < 300) begin tick(); n++; end
    total++; if (dv4 !== 1'b1) $display("FAIL glitch_dv4 got %b want 1", dv4); else pass_cnt++;
    total++; if (int'(data4) != exp4) $display("FAIL glitch_count got %0d want %0d", data4, exp4); else pass_cnt++;
    total++; if (busy4 !== 1'b0) $display("FAIL glitch_busy4 got %b want 0", busy4); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_single_shot();
    test_reset_mid();
    test_boundary();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total);
    $fatal(1);
  end

endmodule
